// File: rtl/audio_pkg.sv
// Shared audio constants for the codec datapath.
//   - Default I2S frame geometry (sample width, slot width).
//   - BCLK divider default derived from the 50 MHz oscillator.
//   - Word-select encoding (LRC_LEFT / LRC_RIGHT).
//   - cnt_width(): counter width helper for small parameterised counters.
package audio_pkg;

  localparam int unsigned OscClkHz       = 50_000_000;
  localparam int unsigned BclkHz         = 3_125_000;
  localparam int unsigned DefSampleWidth = 16;
  localparam int unsigned DefSlotBits    = 32;
  // osc_clk cycles per BCLK half-period
  localparam int unsigned DefBclkDiv     = OscClkHz / (2 * BclkHz);

  localparam logic LRC_LEFT  = 1'b0;
  localparam logic LRC_RIGHT = 1'b1;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S timing generator: BCLK divider, bit counter and word select.
// Ports:
//   clk_i          system clock (osc_clk)
//   rst_i          synchronous active-high reset
//   enable_i       run; low holds the interface idle within one cycle
//   bclk_o         registered bit clock
//   daclrc_o       registered word select (LRC_LEFT / LRC_RIGHT)
//   fall_tick_o    strobe: bclk falls on the next clk_i edge
//   frame_start_o  strobe: fall_tick_o that starts a new frame (bit 0)
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int unsigned SlotBits = DefSlotBits,
  parameter int unsigned BclkDiv  = DefBclkDiv
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic bclk_o,
  output logic daclrc_o,
  output logic fall_tick_o,
  output logic frame_start_o
);

  localparam int unsigned FrameBits = 2 * SlotBits;
  localparam int unsigned DivW      = cnt_width(BclkDiv);
  localparam int unsigned BitW      = cnt_width(FrameBits);
  localparam logic [DivW-1:0] DivLast   = DivW'(BclkDiv - 1);
  localparam logic [BitW-1:0] BitLast   = BitW'(FrameBits - 1);
  localparam logic [BitW-1:0] SlotStart = BitW'(SlotBits);

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d, ws_pos;
  logic            bclk_q, bclk_d, daclrc_q, daclrc_d;
  logic            term, fall_tick, frame_start;

  always_comb begin
    term        = enable_i && (div_cnt_q == DivLast);
    fall_tick   = term && bclk_q;
    frame_start = fall_tick && (bit_cnt_q == BitLast);

    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    bclk_d    = bclk_q;
    daclrc_d  = daclrc_q;
    ws_pos    = '0;

    if (!enable_i) begin
      div_cnt_d = '0;
      bit_cnt_d = BitLast;
      bclk_d    = 1'b0;
      daclrc_d  = LRC_LEFT;
    end else begin
      div_cnt_d = term ? '0 : div_cnt_q + 1'b1;
      if (term) bclk_d = ~bclk_q;
      if (fall_tick) begin
        bit_cnt_d = (bit_cnt_q == BitLast) ? '0 : bit_cnt_q + 1'b1;
        // Word select looks one bit ahead so it changes one BCLK before the slot MSB.
        ws_pos    = (bit_cnt_d == BitLast) ? '0 : bit_cnt_d + 1'b1;
        daclrc_d  = (ws_pos >= SlotStart) ? LRC_RIGHT : LRC_LEFT;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      bit_cnt_q <= BitLast;
      bclk_q    <= 1'b0;
      daclrc_q  <= LRC_LEFT;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      daclrc_q  <= daclrc_d;
    end
  end

  assign bclk_o        = bclk_q;
  assign daclrc_o      = daclrc_q;
  assign fall_tick_o   = fall_tick;
  assign frame_start_o = frame_start;

endmodule

// File: rtl/i2s_dac_tx.sv
// Stereo I2S transmitter driving the codec DAC serial input.
// Ports:
//   osc_clk    system clock (50 MHz); all flops run on it
//   reset      synchronous active-high reset
//   enable     run the serial interface; low holds it idle
//   s_left     left sample (two's complement)
//   s_right    right sample (two's complement)
//   s_valid    sample pair valid
//   s_ready    holding register can accept a pair
//   bclk       I2S bit clock
//   daclrc     word select, 0 = left, 1 = right
//   dacdat     serial data, MSB first, changes only as bclk falls
//   underflow  one-cycle pulse when a frame starts with no pair held
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = DefSampleWidth,
  parameter int unsigned SLOT_BITS    = DefSlotBits,
  parameter int unsigned BCLK_DIV     = DefBclkDiv
) (
  input  logic                    osc_clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] s_left,
  input  logic [SAMPLE_WIDTH-1:0] s_right,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    bclk,
  output logic                    daclrc,
  output logic                    dacdat,
  output logic                    underflow
);

  localparam int unsigned FrameBits = 2 * SLOT_BITS;

  logic                    fall_tick, frame_start, accept;
  logic                    hold_full_q, hold_full_d;
  logic [SAMPLE_WIDTH-1:0] hold_left_q, hold_left_d, hold_right_q, hold_right_d;
  logic [FrameBits-1:0]    shreg_q, shreg_d, frame;
  logic                    dacdat_q, dacdat_d, underflow_q, underflow_d;

  i2s_clkgen #(
    .SlotBits (SLOT_BITS),
    .BclkDiv  (BCLK_DIV)
  ) u_clkgen (
    .clk_i         (osc_clk),
    .rst_i         (reset),
    .enable_i      (enable),
    .bclk_o        (bclk),
    .daclrc_o      (daclrc),
    .fall_tick_o   (fall_tick),
    .frame_start_o (frame_start)
  );

  always_comb begin
    // A pair being consumed this cycle frees the holding register for a new one.
    s_ready = !hold_full_q || frame_start;
    accept  = s_valid && s_ready;

    // Samples sit MSB-aligned in their slots; unused LSBs stay zero.
    frame = '0;
    frame[FrameBits-1 -: SAMPLE_WIDTH] = hold_full_q ? hold_left_q : '0;
    frame[SLOT_BITS-1 -: SAMPLE_WIDTH] = hold_full_q ? hold_right_q : '0;

    hold_full_d  = hold_full_q;
    hold_left_d  = hold_left_q;
    hold_right_d = hold_right_q;
    if (accept) begin
      hold_full_d  = 1'b1;
      hold_left_d  = s_left;
      hold_right_d = s_right;
    end else if (frame_start) begin
      hold_full_d = 1'b0;
    end

    shreg_d     = shreg_q;
    dacdat_d    = dacdat_q;
    underflow_d = frame_start && !hold_full_q;
    if (!enable) begin
      shreg_d  = '0;
      dacdat_d = 1'b0;
    end else if (frame_start) begin
      // Frame MSB goes straight to dacdat; the register keeps the remainder.
      shreg_d  = frame << 1;
      dacdat_d = frame[FrameBits-1];
    end else if (fall_tick) begin
      shreg_d  = shreg_q << 1;
      dacdat_d = shreg_q[FrameBits-1];
    end
  end

  always_ff @(posedge osc_clk) begin
    if (reset) begin
      hold_full_q  <= 1'b0;
      hold_left_q  <= '0;
      hold_right_q <= '0;
      shreg_q      <= '0;
      dacdat_q     <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      hold_full_q  <= hold_full_d;
      hold_left_q  <= hold_left_d;
      hold_right_q <= hold_right_d;
      shreg_q      <= shreg_d;
      dacdat_q     <= dacdat_d;
      underflow_q  <= underflow_d;
    end
  end

  assign dacdat    = dacdat_q;
  assign underflow = underflow_q;

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- Stereo I2S transmitter that feeds the audio codec's DAC serial input (DACDAT) alongside the I2C codec-configuration path.
- Accepts 16-bit left/right PCM sample pairs through a valid/ready handshake and buffers one pair.
- Generates the bit clock (BCLK), the word-select clock (DACLRC) and the serial data (DACDAT), all from osc_clk (50 MHz) using clock enables.
- All outputs are registered; no derived clock drives any internal flop.

Parameters:
- SAMPLE_WIDTH, 16: bits per channel sample.
- SLOT_BITS, 32: BCLK periods per channel slot. Must be ≥ SAMPLE_WIDTH. Unused LSB positions transmit 0.
- BCLK_DIV, 8: osc_clk cycles per BCLK half-period, ≥ 2. Gives BCLK = 3.125 MHz and fs ≈ 48.8 kHz.

Ports:
- osc_clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run the serial interface; when low, the interface is held idle.
- s_left  in  SAMPLE_WIDTH  left sample, two's complement.
- s_right  in  SAMPLE_WIDTH  right sample, two's complement.
- s_valid  in  1  sample pair valid.
- s_ready  out  1  holding register can accept a pair.
- bclk  out  1  I2S bit clock.
- daclrc  out  1  word select: 0 = left, 1 = right.
- dacdat  out  1  serial data, MSB first.
- underflow  out  1  one-cycle pulse when a frame starts with no sample held.

Behaviour:
- Clocking: one clock domain (osc_clk); reset is synchronous and active-high.
- Reset values:
  - Outputs: bclk=0, daclrc=0, dacdat=0, underflow=0, s_ready=1.
  - Internal: hold_full=0, div_cnt=0, bit_cnt=2*SLOT_BITS-1, shift register=0.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 while enable=1. At terminal count, bclk toggles and div_cnt wraps.
  - fall_tick = terminal count while bclk=1, i.e. bclk is about to go low.
- On each fall_tick:
  - bit_cnt advances modulo 2*SLOT_BITS.
  - dacdat takes the next shift-register MSB.
  - daclrc = (((new bit_cnt)+1) mod 2*SLOT_BITS) >= SLOT_BITS. This is standard I2S: word select changes one BCLK before the slot MSB.
- Data changes only on BCLK falling edges, so it is stable at the codec's rising-edge sample point.
- Frame load: on a fall_tick where bit_cnt wraps to 0, the shift register loads {left, zero pad, right, zero pad}. Its MSB drives dacdat in that same cycle.
  - If hold_full=1: the held pair is used, and hold_full clears unless a new pair is accepted in the same cycle.
  - If hold_full=0: an all-zero frame is sent and underflow pulses high for exactly one osc_clk cycle.
- Handshake:
  - Transfer occurs when s_valid && s_ready.
  - s_ready = !hold_full || load_now. A simultaneous consume and accept is legal and keeps hold_full=1 with the new pair.
  - s_left and s_right are captured together. The holding register is never overwritten while full unless it is being consumed in that cycle.
- enable=0:
  - Within one cycle: bclk=0, daclrc=0, dacdat=0; div_cnt=0, bit_cnt=2*SLOT_BITS-1.
  - The holding register is preserved and s_ready still follows hold_full.
- enable rising: the first fall_tick loads a frame starting with the left channel.
- Reset mid-frame: everything returns to reset values on the next edge and any held sample is discarded.
- Latency: a pair accepted while idle-empty appears at dacdat on the next frame boundary, at most 2*SLOT_BITS BCLK periods later.

Decomposition:
- Shared package audio_pkg holds:
  - the SAMPLE_WIDTH and SLOT_BITS defaults;
  - the BCLK_DIV default derived from 50 MHz;
  - the channel-select encoding constants LRC_LEFT=0 and LRC_RIGHT=1.
- Optional sub-module i2s_clkgen: divider, bclk/daclrc generation, fall_tick and frame_start strobes. The parent keeps the holding register and shift register.

Test Plan:
- Reset, then enable=1 with no sample: bclk period = 16 osc_clk cycles; daclrc period = 64 bclk periods with 50% duty; dacdat=0; underflow pulses once per frame (every 1024 cycles).
- Send left=16'hA5C3, right=16'h8001: left slot shows 1010010111000011 followed by 16 zeros; right slot shows 1000000000000001 followed by 16 zeros. Each MSB appears one bclk after the daclrc edge, and dacdat changes only on bclk falling edges.
- Hold s_valid high with back-to-back pairs: s_ready drops after the first accept and rises exactly at frame load. The consume-plus-accept cycle is observed with no frame skipped and no underflow.
- Deassert enable mid-right-slot: outputs reach 0 within one cycle and s_ready stays 0 because the held pair is retained. On re-enable, the held pair is sent as the first frame, left first.
- Assert reset during bit 20 of the left slot with hold_full=1: all outputs return to reset values, s_ready=1, and the next frame after release is all zeros with an underflow pulse.
- Parameter sweep SLOT_BITS=16, BCLK_DIV=2: bclk period = 4 cycles, frame = 32 bclk periods, and samples are transmitted with no padding.
